deser8: RTL and testbench

- Serial-to-parallel receiver: the far end of the 8-bit universal shift register's serial output (S_OUT8).
- Collects framed serial bits, LSB-first or MSB-first, into a data word.
- Presents each completed word on a registered output with a VALID/READY handshake.
- Sits between a serial link fed by the shift-register transmitter and any parallel consumer.

---
 rtl/deser8_pkg.sv | 19 +
 rtl/deser8_rx_shift.sv | 54 +++++
 rtl/deser8.sv | 185 ++++++++++++++++++
 tb/tb_deser8.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/deser8_pkg.sv
// Shared definitions for the deser8 serial-to-parallel receiver:
// FSM state encodings, bit-order encodings and the parity helper.
package deser8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_PAR  = 2'd2
    } state_e;

    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

    // Zero-extension does not change parity, so callers widen to 64 bits.
    function automatic logic odd_total(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/deser8_rx_shift.sv
// Bidirectional serial-in/parallel-out register. word_o is the value the
// register takes on the coming edge, so a completing bit is visible at once.
module rx_shift
    import deser8_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic              dir_i,
    input  logic              bit_i,
    output logic [DATA_W-1:0] word_o
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Next register value: clear, load first bit, shift, or hold.
    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = {DATA_W{1'b0}};
        end else if (load_i) begin
            case (dir_i)
                DIR_LSB: data_d = {bit_i, {(DATA_W-1){1'b0}}};
                DIR_MSB: data_d = {{(DATA_W-1){1'b0}}, bit_i};
                default: data_d = {DATA_W{1'b0}};
            endcase
        end else if (shift_i) begin
            case (dir_i)
                DIR_LSB: data_d = {bit_i, data_q[DATA_W-1:1]};
                DIR_MSB: data_d = {data_q[DATA_W-2:0], bit_i};
                default: data_d = data_q;
            endcase
        end else begin
            data_d = data_q;
        end
    end

    // Shift register state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= {DATA_W{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

    assign word_o = data_d;

endmodule

// File: rtl/deser8.sv
// Framed serial receiver with VALID/READY output and sticky overrun flag.
// Define DESER8_PARITY_EN to add a trailing even-parity bit and the PERR output.
module deser8
    import deser8_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 3
) (
    input  logic              clk_i,
    input  logic              rst_l_i,
    input  logic              enb_i,
    input  logic              sync_i,
    input  logic              dir_i,
    input  logic              s_in_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] q_o,
    output logic              valid_o,
    output logic              busy_o,
`ifdef DESER8_PARITY_EN
    output logic              perr_o,
`endif
    output logic              ovr_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dir_q, dir_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              ovr_q, ovr_d;
`ifdef DESER8_PARITY_EN
    logic              perr_q, perr_d;
`endif

    logic              sh_load_s, sh_shift_s, sh_clr_s, sh_dir_s;
    logic              done_s, accept_s;
    logic [DATA_W-1:0] word_s;

    // The first bit uses the incoming DIR; later bits use the latched one.
    assign sh_dir_s = sh_load_s ? dir_i : dir_q;
    assign accept_s = valid_q & ready_i;

    rx_shift #(.DATA_W(DATA_W)) u_shift (
        .clk_i   (clk_i),
        .rst_ni  (rst_l_i),
        .clr_i   (sh_clr_s),
        .load_i  (sh_load_s),
        .shift_i (sh_shift_s),
        .dir_i   (sh_dir_s),
        .bit_i   (s_in_i),
        .word_o  (word_s)
    );

    // Frame FSM: sequencing, bit counter and shifter control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        sh_load_s  = 1'b0;
        sh_shift_s = 1'b0;
        sh_clr_s   = 1'b0;
        done_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enb_i && sync_i) begin
                    sh_load_s = 1'b1;
                    dir_d     = dir_i;
                    cnt_d     = CNT_W'(1);
                    state_d   = ST_RECV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                // The completing bit is data even if SYNC accompanies it.
                if (enb_i && (cnt_q == LAST_CNT)) begin
                    sh_shift_s = 1'b1;
                    cnt_d      = {CNT_W{1'b0}};
`ifdef DESER8_PARITY_EN
                    state_d    = ST_PAR;
`else
                    done_s     = 1'b1;
                    state_d    = ST_IDLE;
`endif
                end else if (enb_i && sync_i) begin
                    sh_load_s = 1'b1;
                    dir_d     = dir_i;
                    cnt_d     = CNT_W'(1);
                end else if (enb_i) begin
                    sh_shift_s = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_RECV;
                end
            end
`ifdef DESER8_PARITY_EN
            ST_PAR: begin
                if (enb_i && sync_i) begin
                    sh_load_s = 1'b1;
                    dir_d     = dir_i;
                    cnt_d     = CNT_W'(1);
                    state_d   = ST_RECV;
                end else if (enb_i) begin
                    done_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PAR;
                end
            end
`endif
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = {CNT_W{1'b0}};
                sh_clr_s = 1'b1;
            end
        endcase
    end

    // Output word register, handshake and overrun tracking.
    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
`ifdef DESER8_PARITY_EN
        perr_d  = perr_q;
`endif
        if (done_s) begin
            if (!valid_q || ready_i) begin
                q_d     = word_s;
                valid_d = 1'b1;
                ovr_d   = accept_s ? 1'b0 : ovr_q;
`ifdef DESER8_PARITY_EN
                perr_d  = odd_total(64'({word_s, s_in_i}));
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept_s) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_l_i) begin
        if (!rst_l_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            dir_q   <= DIR_LSB;
            q_q     <= {DATA_W{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef DESER8_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
`ifdef DESER8_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign q_o     = q_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign ovr_o   = ovr_q;
`ifdef DESER8_PARITY_EN
    assign perr_o  = perr_q;
`endif

endmodule

// File: tb/tb_deser8.sv
// Randomised and directed bench for deser8 against a frame-level reference
// model built from bit queues (default build, no parity bit).
module tb_deser8;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_l;
    logic              enb, sync, dir, s_in, ready;
    logic [DATA_W-1:0] q;
    logic              valid, busy, ovr;
`ifdef DESER8_PARITY_EN
    logic              perr;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit                m_bits[$];
    bit                m_dir;
    bit                m_busy;
    logic [DATA_W-1:0] exp_q;
    bit                exp_valid;
    bit                exp_ovr;

    deser8 #(.DATA_W(DATA_W), .CNT_W(3)) dut (
        .clk_i   (clk),
        .rst_l_i (rst_l),
        .enb_i   (enb),
        .sync_i  (sync),
        .dir_i   (dir),
        .s_in_i  (s_in),
        .ready_i (ready),
        .q_o     (q),
        .valid_o (valid),
        .busy_o  (busy),
`ifdef DESER8_PARITY_EN
        .perr_o  (perr),
`endif
        .ovr_o   (ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_dir     = 1'b0;
        m_busy    = 1'b0;
        exp_q     = '0;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    // One clock edge of the receiver, described in frame/word terms.
    task automatic model_edge(input bit e, input bit s, input bit d, input bit b, input bit r);
        bit                accept;
        bit                complete;
        logic [DATA_W-1:0] w;
        accept   = exp_valid && r;
        complete = 1'b0;
        w        = '0;
        if (e) begin
            if (m_busy && m_bits.size() == DATA_W - 1) begin
                m_bits.push_back(b);
                for (int i = 0; i < DATA_W; i++) begin
                    if (m_dir) w[DATA_W-1-i] = m_bits[i];
                    else       w[i]          = m_bits[i];
                end
                complete = 1'b1;
                m_bits.delete();
                m_busy = 1'b0;
            end else if (s) begin
                m_bits.delete();
                m_bits.push_back(b);
                m_dir  = d;
                m_busy = 1'b1;
            end else if (m_busy) begin
                m_bits.push_back(b);
            end
        end
        if (complete) begin
            if (!exp_valid || r) begin
                exp_q     = w;
                exp_valid = 1'b1;
                if (accept) exp_ovr = 1'b0;
            end else begin
                exp_ovr = 1'b1;
            end
        end else if (accept) begin
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
        end
    endtask

    task automatic step(input bit e, input bit s, input bit d, input bit b, input bit r);
        enb = e; sync = s; dir = d; s_in = b; ready = r;
        @(posedge clk);
        model_edge(e, s, d, b, r);
        #1;
        chk("q", 32'(q), 32'(exp_q));
        chk("valid", 32'(valid), 32'(exp_valid));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("ovr", 32'(ovr), 32'(exp_ovr));
    endtask

    task automatic send_word(input logic [7:0] w, input bit d, input int gap,
                             input bit r, input bit r_last);
        bit b;
        for (int i = 0; i < 8; i++) begin
            b = d ? w[7-i] : w[i];
            step(1'b1, i == 0, d, b, (i == 7) ? r_last : r);
            if (i < 7) begin
                chk("busy_in_frame", 32'(busy), 32'd1);
                for (int g = 0; g < gap; g++) step(1'b0, 1'b0, d, 1'b0, r);
            end
        end
    endtask

    initial begin
        rst_l = 1'b0; enb = 1'b0; sync = 1'b0; dir = 1'b0; s_in = 1'b0; ready = 1'b0;
        model_reset();
        #12;
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        rst_l = 1'b1;
        @(posedge clk); #1;

        // LSB-first word with READY low
        send_word(8'hA5, 1'b0, 0, 1'b0, 1'b0);
        chk("lsb_q", 32'(q), 32'hA5);
        chk("lsb_valid", 32'(valid), 32'd1);
        chk("lsb_busy", 32'(busy), 32'd0);

        // Overrun keeps the pending word, acceptance clears the flag
        send_word(8'h11, 1'b0, 0, 1'b0, 1'b0);
        chk("ovr_q", 32'(q), 32'hA5);
        chk("ovr_set", 32'(ovr), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_acc_valid", 32'(valid), 32'd0);
        chk("ovr_acc_ovr", 32'(ovr), 32'd0);

        // MSB-first with idle gaps between strobes
        send_word(8'h3C, 1'b1, 2, 1'b0, 1'b0);
        chk("msb_q", 32'(q), 32'h3C);
        chk("msb_valid", 32'(valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back: accept on the completion edge of the next word
        send_word(8'hA5, 1'b0, 0, 1'b0, 1'b0);
        send_word(8'h5A, 1'b0, 0, 1'b0, 1'b1);
        chk("b2b_q", 32'(q), 32'h5A);
        chk("b2b_valid", 32'(valid), 32'd1);
        chk("b2b_ovr", 32'(ovr), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Restart after four bits, then a full word
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1, 1'b0, 1'b0);
        send_word(8'hFF, 1'b0, 1, 1'b0, 1'b0);
        chk("restart_q", 32'(q), 32'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'b0, 1'b1, 1'b0);
        #1 rst_l = 1'b0;
        #1;
        model_reset();
        chk("midrst_q", 32'(q), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ovr", 32'(ovr), 32'd0);
        #2 rst_l = 1'b1;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 4) != 0, ($urandom % 16) == 0, $urandom % 2,
                 $urandom % 2, ($urandom % 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
